// File: rtl/irq_timer_bank.sv
// irq_timer_bank: NCH independent down-counting interval timers, each advanced by
// a one-cycle Tick per 6502 cycle. Every channel has a reload value, a periodic or
// one-shot mode, a pending Flag that clears on read, and an IRQ enable. An IRQ
// enable can only be set after the C1/AD key sequence has unlocked the bank.
//
// Ports
//   C7M      in   7M clock, all state changes on posedge
//   RES      in   asynchronous active-high reset
//   Tick     in   one-C7M pulse per 6502 cycle
//   RegWR    in   register write strobe
//   RegRD    in   register read strobe
//   RegA     in   [4:0] register address
//   RegDin   in   [7:0] write data
//   RegDout  out  [7:0] read data, combinational, 0 when RegRD=0
//   IRQ      out  registered OR of Flag & IRQEN over all channels
//
// Map: channel i at 4*i: +0 reload lo, +1 reload hi, +2 ctrl {IRQEN,ONESHOT,..,RUN},
// +3 status {Flag,0}; 1E pending flags; 1F key write / {Unlock,7'h06} read.

// One timer channel: reload/ctrl/flag registers plus the counter.
module irq_timer_ch #(
    parameter int TW      = 15,
    parameter int DEFLOAD = 17029
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          unlock_i,
    input  logic          lock_i,      // key AC sequence: force IRQEN off
    input  logic          wr_lo_i,
    input  logic          wr_hi_i,
    input  logic          wr_ctrl_i,
    input  logic          rd_stat_i,   // status read, already masked by RegWR
    input  logic [7:0]    din_i,
    output logic [TW-1:0] reload_o,
    output logic          irqen_o,
    output logic          oneshot_o,
    output logic          run_o,
    output logic          flag_o
);
    logic [TW-1:0] reload_q, reload_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          irqen_q, irqen_d;
    logic          oneshot_q, oneshot_d;
    logic          run_q, run_d;
    logic          flag_q, flag_d;

    always_comb begin
        reload_d  = reload_q;
        cnt_d     = cnt_q;
        irqen_d   = irqen_q;
        oneshot_d = oneshot_q;
        run_d     = run_q;
        flag_d    = flag_q;

        // Bits 0..7 come from the lo write, bits 8.. from the hi write;
        // 3'(b) picks the matching data bit in either byte.
        for (int b = 0; b < TW; b++)
            if ((b < 8) ? wr_lo_i : wr_hi_i)
                reload_d[b] = din_i[3'(b)];

        if (rd_stat_i)
            flag_d = 1'b0;

        // The 0 state always reloads, so the counter never underflows.
        // Flag is set after the rd clear so a coincident set wins.
        if (tick_i && run_q) begin
            if (cnt_q == '0)
                cnt_d = reload_q;
            else
                cnt_d = cnt_q - TW'(1);
            if (cnt_q == TW'(1)) begin
                flag_d = 1'b1;
                if (oneshot_q)
                    run_d = 1'b0;
            end
        end

        // A RUN 0->1 write loads the counter, overriding a same-edge tick.
        if (wr_ctrl_i) begin
            irqen_d   = din_i[7] & unlock_i;
            oneshot_d = din_i[6];
            run_d     = din_i[0];
            if (din_i[0] && !run_q)
                cnt_d = reload_q;
        end

        if (lock_i)
            irqen_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reload_q  <= TW'(DEFLOAD);
            cnt_q     <= '0;
            irqen_q   <= 1'b0;
            oneshot_q <= 1'b0;
            run_q     <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            reload_q  <= reload_d;
            cnt_q     <= cnt_d;
            irqen_q   <= irqen_d;
            oneshot_q <= oneshot_d;
            run_q     <= run_d;
            flag_q    <= flag_d;
        end
    end

    assign reload_o  = reload_q;
    assign irqen_o   = irqen_q;
    assign oneshot_o = oneshot_q;
    assign run_o     = run_q;
    assign flag_o    = flag_q;
endmodule

module irq_timer_bank #(
    parameter int NCH     = 2,
    parameter int TW      = 15,
    parameter int DEFLOAD = 17029
) (
    input  logic       C7M,
    input  logic       RES,
    input  logic       Tick,
    input  logic       RegWR,
    input  logic       RegRD,
    input  logic [4:0] RegA,
    input  logic [7:0] RegDin,
    output logic [7:0] RegDout,
    output logic       IRQ
);
    typedef enum logic {K_IDLE, K_KEY1} key_t;

    key_t                   key_q, key_d;
    logic                   unlock_q, unlock_d;
    logic                   lock_all;
    logic                   irq_q;
    logic                   key_wr;
    logic                   rd_eff;
    logic [2:0]             chan;
    logic [1:0]             off;
    logic [15:0]            rl_ext;

    logic [NCH-1:0][TW-1:0] reload;
    logic [NCH-1:0]         irqen, oneshot, run, flag;

    // A write in the same cycle as a read suppresses all read side effects.
    assign rd_eff = RegRD & ~RegWR;
    assign chan   = RegA[4:2];
    assign off    = RegA[1:0];
    assign key_wr = RegWR && (RegA == 5'h1F);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel;
        assign sel = (chan == 3'(i));

        irq_timer_ch #(.TW(TW), .DEFLOAD(DEFLOAD)) u_ch (
            .clk_i     (C7M),
            .rst_i     (RES),
            .tick_i    (Tick),
            .unlock_i  (unlock_q),
            .lock_i    (lock_all),
            .wr_lo_i   (RegWR && sel && off == 2'd0),
            .wr_hi_i   (RegWR && sel && off == 2'd1),
            .wr_ctrl_i (RegWR && sel && off == 2'd2),
            .rd_stat_i (rd_eff && sel && off == 2'd3),
            .din_i     (RegDin),
            .reload_o  (reload[i]),
            .irqen_o   (irqen[i]),
            .oneshot_o (oneshot[i]),
            .run_o     (run[i]),
            .flag_o    (flag[i])
        );
    end

    // Key FSM: any access other than the second key byte abandons KEY1.
    always_comb begin
        key_d    = key_q;
        unlock_d = unlock_q;
        lock_all = 1'b0;
        case (key_q)
            K_IDLE: begin
                if (key_wr && RegDin == 8'hC1)
                    key_d = K_KEY1;
            end
            K_KEY1: begin
                if (key_wr && RegDin == 8'hAD) begin
                    unlock_d = 1'b1;
                    key_d    = K_IDLE;
                end else if (key_wr && RegDin == 8'hAC) begin
                    unlock_d = 1'b0;
                    lock_all = 1'b1;
                    key_d    = K_IDLE;
                end else if (RegWR || RegRD) begin
                    key_d = K_IDLE;
                end
            end
            default: key_d = K_IDLE;
        endcase
    end

    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            key_q    <= K_IDLE;
            unlock_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            key_q    <= key_d;
            unlock_q <= unlock_d;
            irq_q    <= |(flag & irqen);
        end
    end

    // Channel indices never reach 7, so 1E/1F never alias a channel.
    always_comb begin
        RegDout = 8'h00;
        rl_ext  = 16'h0000;
        if (RegRD) begin
            if (RegA == 5'h1E)
                RegDout = 8'(flag);
            else if (RegA == 5'h1F)
                RegDout = {unlock_q, 7'h06};
            else
                for (int i = 0; i < NCH; i++)
                    if (chan == 3'(i)) begin
                        rl_ext = 16'(reload[i]);
                        case (off)
                            2'd0:    RegDout = rl_ext[7:0];
                            2'd1:    RegDout = rl_ext[15:8];
                            2'd2:    RegDout = {irqen[i], oneshot[i], 5'b0, run[i]};
                            default: RegDout = {flag[i], 7'b0};
                        endcase
                    end
        end
    end

    assign IRQ = irq_q;
endmodule

// File: tb/tb_irq_timer_bank.sv
// Directed bench for irq_timer_bank. Stimulus tasks push the expected value of
// each read or IRQ probe into a scoreboard queue; the monitor pops and compares
// at the negedge of every cycle where RegRD or irq_probe is active.
module tb_irq_timer_bank;
    logic       C7M = 1'b0;
    logic       RES = 1'b1;
    logic       Tick = 1'b0;
    logic       RegWR = 1'b0;
    logic       RegRD = 1'b0;
    logic [4:0] RegA = 5'h00;
    logic [7:0] RegDin = 8'h00;
    logic [7:0] RegDout;
    logic       IRQ;
    logic       irq_probe = 1'b0;

    typedef struct {
        string      name;
        logic [7:0] exp;
        bit         is_irq;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    irq_timer_bank #(.NCH(2), .TW(15), .DEFLOAD(17029)) dut (
        .C7M     (C7M),
        .RES     (RES),
        .Tick    (Tick),
        .RegWR   (RegWR),
        .RegRD   (RegRD),
        .RegA    (RegA),
        .RegDin  (RegDin),
        .RegDout (RegDout),
        .IRQ     (IRQ)
    );

    always #5 C7M = ~C7M;

    // Monitor
    always @(negedge C7M) begin
        if (RegRD || irq_probe) begin
            exp_t       e;
            logic [7:0] act;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: DUT output with no expected entry");
            end else begin
                e   = sb.pop_front();
                act = e.is_irq ? {7'b0, IRQ} : RegDout;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push(input string n, input logic [7:0] e, input bit is_irq);
        exp_t x;
        x.name = n; x.exp = e; x.is_irq = is_irq;
        sb.push_back(x);
    endtask

    task automatic cyc();
        @(posedge C7M); #1;
        RegWR = 1'b0; RegRD = 1'b0; Tick = 1'b0; irq_probe = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        RegA = a; RegDin = d; RegWR = 1'b1; cyc();
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e, input string n);
        push(n, e, 1'b0); RegA = a; RegRD = 1'b1; cyc();
    endtask

    task automatic rd_tick(input logic [4:0] a, input logic [7:0] e, input string n);
        push(n, e, 1'b0); RegA = a; RegRD = 1'b1; Tick = 1'b1; cyc();
    endtask

    task automatic wrrd(input logic [4:0] a, input logic [7:0] d, input logic [7:0] e, input string n);
        push(n, e, 1'b0); RegA = a; RegDin = d; RegWR = 1'b1; RegRD = 1'b1; cyc();
    endtask

    task automatic chk_irq(input bit e, input string n);
        push(n, {7'b0, e}, 1'b1); irq_probe = 1'b1; cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin Tick = 1'b1; cyc(); end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge C7M);
        #1 RES = 1'b0;

        // Reset state
        rd(5'h00, 8'h85, "rst_rl0_lo");
        rd(5'h01, 8'h42, "rst_rl0_hi");
        rd(5'h02, 8'h00, "rst_ctrl0");
        rd(5'h03, 8'h00, "rst_stat0");
        rd(5'h05, 8'h42, "rst_rl1_hi");
        rd(5'h1E, 8'h00, "rst_pend");
        rd(5'h1F, 8'h06, "rst_key");
        rd(5'h10, 8'h00, "unmapped");
        chk_irq(1'b0, "rst_irq");

        // Periodic, locked: reload=4 -> Flag every 5 ticks, IRQ stays 0
        wr(5'h00, 8'h04);
        wr(5'h01, 8'h00);
        wr(5'h02, 8'h01);
        ticks(3);
        rd(5'h1E, 8'h00, "per_pend_early");
        ticks(1);
        rd(5'h1E, 8'h01, "per_pend_set");
        rd(5'h1E, 8'h01, "per_pend_noclr");
        chk_irq(1'b0, "per_irq_locked");
        rd(5'h03, 8'h80, "per_stat_set");
        rd(5'h03, 8'h00, "per_stat_clr");
        ticks(4);
        rd(5'h03, 8'h00, "per_stat_p2_early");
        ticks(1);
        rd(5'h03, 8'h80, "per_stat_p2");
        wr(5'h02, 8'h00);

        // Locked IRQEN write and aborted key sequence
        wr(5'h02, 8'h81);
        rd(5'h02, 8'h01, "lock_ctrl");
        wr(5'h1F, 8'hC1);
        rd(5'h00, 8'h04, "abort_rd");
        wr(5'h1F, 8'hAD);
        rd(5'h1F, 8'h06, "abort_still_locked");
        wr(5'h02, 8'h00);

        // Unlock, IRQ latency and read-clear
        wr(5'h1F, 8'hC1);
        wr(5'h1F, 8'hAD);
        rd(5'h1F, 8'h86, "unlocked");
        wr(5'h02, 8'h81);
        rd(5'h02, 8'h81, "ctrl_irqen");
        ticks(3);
        chk_irq(1'b0, "irq_before");
        ticks(1);
        chk_irq(1'b0, "irq_flag_edge");
        chk_irq(1'b1, "irq_one_later");
        rd(5'h03, 8'h80, "irq_stat_rd");
        chk_irq(1'b1, "irq_hold");
        chk_irq(1'b0, "irq_dropped");

        // Clearing IRQEN drops IRQ but leaves Flag pending
        ticks(5);
        idle(1);
        chk_irq(1'b1, "irq_p2");
        wr(5'h02, 8'h01);
        chk_irq(1'b1, "irqen_clr_hold");
        chk_irq(1'b0, "irqen_clr_drop");
        rd(5'h1E, 8'h01, "irqen_clr_pend");
        rd(5'h03, 8'h80, "irqen_clr_stat");

        // Read-clear on the same edge as the set: set wins
        wr(5'h02, 8'h00);
        wr(5'h02, 8'h01);
        ticks(3);
        rd_tick(5'h03, 8'h00, "race_rd");
        rd(5'h03, 8'h80, "race_flag_kept");
        // Write with read in the same cycle: no read-clear
        ticks(5);
        wrrd(5'h03, 8'h00, 8'h80, "wrrd_data");
        rd(5'h03, 8'h80, "wrrd_flag_kept");
        rd(5'h03, 8'h00, "wrrd_clr_after");
        wr(5'h02, 8'h00);

        // Relock with AC clears IRQEN
        wr(5'h02, 8'h80);
        rd(5'h02, 8'h80, "relock_pre");
        wr(5'h1F, 8'hC1);
        wr(5'h1F, 8'hAC);
        rd(5'h02, 8'h00, "relock_irqen");
        rd(5'h1F, 8'h06, "relock_key");
        wr(5'h1F, 8'hC1);
        wr(5'h1F, 8'hAD);

        // One-shot on channel 1, reload=3
        wr(5'h04, 8'h03);
        wr(5'h05, 8'h00);
        rd(5'h04, 8'h03, "os_rl");
        wr(5'h06, 8'h41);
        ticks(2);
        rd(5'h07, 8'h00, "os_early");
        ticks(1);
        rd(5'h07, 8'h80, "os_flag");
        rd(5'h06, 8'h40, "os_run_off");
        ticks(3);
        rd(5'h07, 8'h00, "os_no_refire");
        rd(5'h1E, 8'h00, "os_pend");

        // Async reset mid-count with IRQ asserted
        wr(5'h00, 8'hF4);
        wr(5'h01, 8'h01);
        rd(5'h01, 8'h01, "rl500_hi");
        wr(5'h06, 8'hC1);
        ticks(3);
        wr(5'h02, 8'h01);
        chk_irq(1'b1, "pre_res_irq");
        rd(5'h1E, 8'h02, "pre_res_pend");
        push("res_irq_async", 8'h00, 1'b1);
        RES = 1'b1; irq_probe = 1'b1;
        cyc();
        RES = 1'b0;
        rd(5'h00, 8'h85, "res_rl0_lo");
        rd(5'h01, 8'h42, "res_rl0_hi");
        rd(5'h04, 8'h85, "res_rl1_lo");
        rd(5'h02, 8'h00, "res_ctrl0");
        rd(5'h1E, 8'h00, "res_pend");
        rd(5'h1F, 8'h06, "res_unlock");
        chk_irq(1'b0, "res_irq");

        idle(2);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
